// File: rtl/stack_seq_pkg.sv
// Shared opcodes, FSM state encoding and default sizes for the stack command sequencer.
// Also holds the operand-count decode used by the IDLE legality check.
package stack_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 32;
  localparam int PTR_W_DEF  = 6;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_TOP  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_POP_A, S_RD_B, S_POP_B, S_PUSH_R, S_RESP
  } state_t;

  // Number of stack entries an opcode consumes before it can execute.
  function automatic logic [1:0] operands_needed(input logic [2:0] op);
    case (op)
      OP_POP, OP_TOP, OP_NOT: operands_needed = 2'd1;
      OP_ADD, OP_SUB, OP_AND: operands_needed = 2'd2;
      default:                operands_needed = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Command/response handshake between a command source and the stack sequencer.
// The source is the master; the sequencer is the slave.
interface stack_seq_if
  import stack_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_imm;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_imm,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_seq_alu.sv
// Combinational ALU for the sequencer: opB is the second element, opA the top of stack.
// Results wrap modulo 2**DATA_W; opcodes that do not compute return zero.
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = op_b + op_a;
      OP_SUB:  result = op_b - op_a;
      OP_AND:  result = op_b & op_a;
      OP_NOT:  result = ~op_a;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/stack_op_sequencer.sv
// Runs push/pop/tos strobe sequences against an external stack for one command at a time,
// keeping a shadow depth so overflow/underflow are reported instead of silently dropped.
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  stack_seq_if.slave        cmd,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_tos,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [PTR_W-1:0]  depth
);
  state_t            state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              illegal;

  assign cmd.cmd_ready = ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_err   = rsp_err_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign stk_tos       = (state == S_RD_A) || (state == S_RD_B);

  assign illegal = (PTR_W'(operands_needed(cmd.cmd_op)) > depth) ||
                   ((cmd.cmd_op == OP_PUSH) && (depth == PTR_W'(DEPTH)));

  stack_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .op_a   (op_a),
    .op_b   (op_b),
    .result (alu_res)
  );

  // Operand capture has no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    if (state == S_RD_A) op_a <= stk_dout;
    if (state == S_RD_B) op_b <= stk_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_din     <= '0;
      depth       <= '0;
    end else begin
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      // Depth tracks the strobe cycle that just completed.
      if (stk_push)     depth <= depth + PTR_W'(1);
      else if (stk_pop) depth <= depth - PTR_W'(1);

      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            ready_q    <= 1'b0;
            op_q       <= cmd.cmd_op;
            rsp_data_q <= '0;
            if (illegal) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (cmd.cmd_op == OP_NOP) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else if (cmd.cmd_op == OP_PUSH) begin
              state    <= S_PUSH_R;
              stk_push <= 1'b1;
              stk_din  <= cmd.cmd_imm;
            end else begin
              state <= S_RD_A;
            end
          end
        end
        S_RD_A: begin
          if (op_q == OP_TOP) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= stk_dout;
          end else begin
            state   <= S_POP_A;
            stk_pop <= 1'b1;
          end
        end
        S_POP_A: begin
          if (op_q == OP_POP) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= op_a;
          end else if (op_q == OP_NOT) begin
            state    <= S_PUSH_R;
            stk_push <= 1'b1;
            stk_din  <= alu_res;
          end else begin
            state <= S_RD_B;
          end
        end
        S_RD_B: begin
          state   <= S_POP_B;
          stk_pop <= 1'b1;
        end
        S_POP_B: begin
          state    <= S_PUSH_R;
          stk_push <= 1'b1;
          stk_din  <= alu_res;
        end
        S_PUSH_R: begin
          state       <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= (op_q == OP_PUSH) ? '0 : stk_din;
        end
        S_RESP: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: behavioural stack model plus a response scoreboard.
module tb_stack_op_sequencer;
  import stack_seq_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int PTR_W  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_seq_if #(.DATA_W(DATA_W)) bus ();

  logic              stk_push, stk_pop, stk_tos;
  logic [DATA_W-1:0] stk_din, stk_dout;
  logic [PTR_W-1:0]  depth;

  stack_op_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (bus.slave),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_tos  (stk_tos),
    .stk_din  (stk_din),
    .stk_dout (stk_dout),
    .depth    (depth)
  );

  // Stack model: no reset of its own, cleared explicitly through stk_clr.
  logic [DATA_W-1:0] mem [DEPTH];
  int   sp = 0;
  logic stk_clr = 1'b1;
  always @(posedge clk) begin
    if (stk_clr) sp <= 0;
    else if (stk_push && sp < DEPTH) begin
      mem[5'(sp)] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_dout = (sp > 0) ? mem[5'(sp - 1)] : '0;

  int cyc = 0, push_cnt = 0, pop_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop)  pop_cnt  <= pop_cnt + 1;
  end

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
    int                lat;
    int                acc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic monitor();
    exp_t x;
    int   lat;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (stk_push && stk_pop) begin
          errors++;
          $display("FAIL strobe_excl push=%b pop=%b required at most one", stk_push, stk_pop);
        end
        if (bus.rsp_valid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected data=%h err=%b required no response", bus.rsp_data, bus.rsp_err);
          end else begin
            x   = sb.pop_front();
            lat = cyc - x.acc + 1;
            if (bus.rsp_data !== x.d || bus.rsp_err !== x.e || lat != x.lat) begin
              errors++;
              $display("FAIL rsp data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                       bus.rsp_data, bus.rsp_err, lat, x.d, x.e, x.lat);
            end
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] imm,
                       input logic [DATA_W-1:0] d, input logic e, input int lat);
    exp_t x;
    int   n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout op=%0d cmd_ready=%b required 1", op, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_imm   = imm;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_imm   = 8'h5A;
    x.d = d; x.e = e; x.lat = lat; x.acc = cyc;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !bus.cmd_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [DATA_W-1:0] imm,
                        input logic [DATA_W-1:0] d, input logic e, input int lat);
    issue(op, imm, d, e, lat);
    wait_idle();
  endtask

  task automatic check_depth(input string name, input int exp);
    checks++;
    if (depth !== PTR_W'(exp)) begin
      errors++;
      $display("FAIL %s depth=%0d required %0d", name, depth, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required 1", bus.cmd_ready); end
    check_depth("reset_depth", 0);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b required 0", bus.rsp_valid); end
    checks++;
    if (stk_push !== 1'b0 || stk_pop !== 1'b0) begin
      errors++; $display("FAIL reset_strobes push=%b pop=%b required 0 0", stk_push, stk_pop);
    end
  endtask

  task automatic test_add();
    do_cmd(OP_PUSH, 8'h03, 8'h00, 1'b0, 2);
    do_cmd(OP_PUSH, 8'h05, 8'h00, 1'b0, 2);
    issue(OP_ADD, 8'h00, 8'h08, 1'b0, 6);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b required 0", bus.cmd_ready); end
    wait_idle();
    check_depth("add_depth", 1);
    issue(OP_TOP, 8'h00, 8'h08, 1'b0, 2);
    checks++;
    if (stk_tos !== 1'b1) begin errors++; $display("FAIL top_tos got=%b required 1", stk_tos); end
    wait_idle();
    do_cmd(OP_POP, 8'h00, 8'h08, 1'b0, 3);
    check_depth("add_pop_depth", 0);
  endtask

  task automatic test_sub_not();
    do_cmd(OP_PUSH, 8'h03, 8'h00, 1'b0, 2);
    do_cmd(OP_PUSH, 8'h05, 8'h00, 1'b0, 2);
    do_cmd(OP_SUB,  8'h00, 8'hFE, 1'b0, 6);
    check_depth("sub_depth", 1);
    do_cmd(OP_PUSH, 8'h0F, 8'h00, 1'b0, 2);
    do_cmd(OP_NOT,  8'h00, 8'hF0, 1'b0, 4);
    check_depth("not_depth", 2);
    do_cmd(OP_POP,  8'h00, 8'hF0, 1'b0, 3);
    do_cmd(OP_POP,  8'h00, 8'hFE, 1'b0, 3);
    check_depth("sub_not_drain", 0);
  endtask

  task automatic test_underflow();
    int p0;
    p0 = pop_cnt;
    do_cmd(OP_POP, 8'h00, 8'h00, 1'b1, 1);
    checks++;
    if (pop_cnt != p0) begin errors++; $display("FAIL underflow_pop pulses=%0d required 0", pop_cnt - p0); end
    check_depth("underflow_depth", 0);
    do_cmd(OP_PUSH, 8'h07, 8'h00, 1'b0, 2);
    do_cmd(OP_ADD,  8'h00, 8'h00, 1'b1, 1);
    check_depth("add_one_depth", 1);
    do_cmd(OP_POP,  8'h00, 8'h07, 1'b0, 3);
  endtask

  task automatic test_full();
    int p0;
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH, 8'(i), 8'h00, 1'b0, 2);
    check_depth("full_depth", DEPTH);
    p0 = push_cnt;
    do_cmd(OP_PUSH, 8'hAA, 8'h00, 1'b1, 1);
    checks++;
    if (push_cnt != p0) begin errors++; $display("FAIL overflow_push pulses=%0d required 0", push_cnt - p0); end
    check_depth("overflow_depth", DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--) do_cmd(OP_POP, 8'h00, 8'(i), 1'b0, 3);
    check_depth("drain_depth", 0);
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH, 8'(i), 8'h00, 1'b0, 2);
    do_cmd(OP_ADD, 8'h00, 8'd61, 1'b0, 6);
    check_depth("full_add_depth", DEPTH - 1);
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_imm   = 8'h00;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stk_pop !== 1'b1) begin errors++; $display("FAIL pop_b_strobe got=%b required 1", stk_pop); end
    rst = 1'b1;
    stk_clr = 1'b1;
    #1;
    checks++;
    if (stk_pop !== 1'b0) begin errors++; $display("FAIL midrst_pop got=%b required 0", stk_pop); end
    check_depth("midrst_depth", 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk_clr = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready ready=%b rsp_valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
    end
    check_depth("post_rst_depth", 0);
  endtask

  task automatic test_back_to_back();
    do_cmd(OP_PUSH, 8'h0C, 8'h00, 1'b0, 2);
    do_cmd(OP_PUSH, 8'h0A, 8'h00, 1'b0, 2);
    issue(OP_AND, 8'h00, 8'h08, 1'b0, 6);
    issue(OP_NOP, 8'h00, 8'h00, 1'b0, 1);
    issue(OP_TOP, 8'h00, 8'h08, 1'b0, 2);
    issue(OP_POP, 8'h00, 8'h08, 1'b0, 3);
    wait_idle();
    check_depth("b2b_depth", 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_imm   = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_add();
    test_sub_not();
    test_underflow();
    test_full();
    test_mid_reset();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
